// File: rtl/macc_pkg.sv
// Shared constants and state encoding for the x29 MACC frame sequencer.
package macc_pkg;

   localparam int MACC_PIPE_DEPTH = 2;
   localparam int MACC_COEF       = 29;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TAIL = 2'd2
   } state_t;

endpackage

// File: rtl/macc_tag_pipe.sv
// Last-sample tag shift register that tracks frame ends through the MACC pipe.
module macc_tag_pipe
   import macc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic last_in,
   input  logic sample_acc,
   output logic in_flight,
   output logic tag_exit,
   output logic flush_need
);

   logic [MACC_PIPE_DEPTH-1:0] tag_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_p0 <= '0;
      end else if (ce) begin
         tag_p0 <= {tag_p0[MACC_PIPE_DEPTH-2:0], last_in};
      end
   end

   // The MACC sum is complete on the ce-edge that shifts the oldest tag out.
   assign in_flight  = |tag_p0;
   assign tag_exit   = ce & tag_p0[MACC_PIPE_DEPTH-1];
   assign flush_need = in_flight & ~sample_acc;

endmodule

// File: rtl/macc_frame_ctrl.sv
// Frame sequencer: feeds samples to an external x29 MACC and returns one sum per frame.
module macc_frame_ctrl
   import macc_pkg::*;
#(
   parameter int SIZEIN  = 16,
   parameter int SIZEOUT = 40,
   parameter int LEN_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LEN_W-1:0]          cfg_len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [SIZEIN-1:0]  in_data,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic signed [SIZEOUT-1:0] res_data,
   output logic                      busy,
   output logic                      macc_ce,
   output logic                      macc_sload,
   output logic signed [SIZEIN-1:0]  macc_a,
   input  logic signed [SIZEOUT-1:0] macc_accum
);

   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
      return (l == '0) ? LEN_W'(1) : l;
   endfunction

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              first_d;
   logic              rdy_en_q;
   logic              pend_q;
   logic              res_valid_q;
   logic signed [SIZEOUT-1:0] res_data_q;

   logic stall, accept, ce, capture, last_acc, is_first;
   logic in_flight, tag_exit, flush_need;

   // A finished sum must not be overwritten while the result port is blocked.
   assign stall    = res_valid_q & ~res_ready & (in_flight | pend_q);
   assign in_ready = rdy_en_q & ~stall;
   assign accept   = in_valid & in_ready;
   assign ce       = accept | (flush_need & ~stall);
   assign capture  = pend_q & (~res_valid_q | res_ready);
   assign is_first = (state_q != RUN);

   macc_tag_pipe u_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .last_in    (last_acc),
      .sample_acc (accept),
      .in_flight  (in_flight),
      .tag_exit   (tag_exit),
      .flush_need (flush_need)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      last_acc = 1'b0;
      case (state_q)
         IDLE, TAIL: begin
            if (accept) begin
               len_d = eff_len(cfg_len);
               cnt_d = LEN_W'(1);
               if (eff_len(cfg_len) == LEN_W'(1)) begin
                  last_acc = 1'b1;
                  state_d  = TAIL;
               end else begin
                  state_d  = RUN;
               end
            end else if (state_q == TAIL && !in_flight) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (accept) begin
               if (cnt_q == len_q - LEN_W'(1)) begin
                  last_acc = 1'b1;
                  cnt_d    = '0;
                  state_d  = TAIL;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // sload follows the first sample by one ce-cycle to clear the accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_d     <= 1'b0;
         rdy_en_q    <= 1'b0;
         pend_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         if (ce) begin
            first_d <= accept & is_first;
         end
         pend_q <= tag_exit | (pend_q & ~capture);
         if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= macc_accum;
         end else if (res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign busy       = (state_q != IDLE) | in_flight | pend_q;
   assign macc_ce    = ce;
   assign macc_sload = first_d;
   assign macc_a     = accept ? in_data : '0;

endmodule

// File: tb/tb_macc_frame_ctrl.sv
// Bench for macc_frame_ctrl with a behavioural x29 MACC and a result scoreboard.
module tb_macc_frame_ctrl;

   localparam int SIZEIN  = 16;
   localparam int SIZEOUT = 40;
   localparam int LEN_W   = 8;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [LEN_W-1:0]          cfg_len;
   logic                      in_valid;
   logic                      in_ready;
   logic signed [SIZEIN-1:0]  in_data;
   logic                      res_valid;
   logic                      res_ready;
   logic signed [SIZEOUT-1:0] res_data;
   logic                      busy;
   logic                      macc_ce;
   logic                      macc_sload;
   logic signed [SIZEIN-1:0]  macc_a;
   logic signed [SIZEOUT-1:0] macc_accum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   macc_frame_ctrl #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_len    (cfg_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .busy       (busy),
      .macc_ce    (macc_ce),
      .macc_sload (macc_sload),
      .macc_a     (macc_a),
      .macc_accum (macc_accum)
   );

   // MACC model: accum after edge i = (sload_(i-1) ? 0 : accum) + 29*a_(i-2)
   logic signed [SIZEIN-1:0]  m_a1 = '0, m_a2 = '0;
   logic                      m_sl = 1'b0;
   logic signed [SIZEOUT-1:0] m_acc = '0;
   logic signed [SIZEOUT-1:0] m_ax;
   assign m_ax       = m_a2;
   assign macc_accum = m_acc;

   always @(posedge clk) begin
      if (macc_ce) begin
         m_acc <= (m_sl ? '0 : m_acc) + m_ax * 40'sd29;
         m_a2  <= m_a1;
         m_a1  <= macc_a;
         m_sl  <= macc_sload;
      end
   end

   logic signed [SIZEOUT-1:0] exp_q[$];
   longint                    run_sum = 0;
   int                        ce_idx = 0, flush_cnt = 0, res_cnt = 0;
   logic [31:0]               sload_mask = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (macc_ce) begin
            if (macc_sload && ce_idx < 32) sload_mask[ce_idx] = 1'b1;
            if (!(in_valid && in_ready)) begin
               flush_cnt++;
               checks++;
               if (macc_a !== '0) begin
                  errors++;
                  $display("FAIL flush_a: got %0d expected 0", macc_a);
               end
            end
            ce_idx++;
         end
         if (res_valid && res_ready) begin
            res_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL res_unexpected: got %0d with no result expected", res_data);
            end else begin
               logic signed [SIZEOUT-1:0] e;
               e = exp_q.pop_front();
               if (res_data !== e) begin
                  errors++;
                  $display("FAIL res_data: got %0d expected %0d", res_data, e);
               end
            end
         end
      end
   end

   task automatic clear_stats();
      ce_idx = 0; flush_cnt = 0; res_cnt = 0; sload_mask = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic signed [SIZEIN-1:0] d, input bit last);
      bit ok, got;
      in_valid = 1'b1;
      in_data  = d;
      got      = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
         if (ok) begin got = 1'b1; break; end
      end
      in_valid = 1'b0;
      in_data  = '0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_timeout: sample %0d not accepted within 200 cycles", d);
      end else begin
         run_sum += d;
         if (last) begin
            exp_q.push_back(SIZEOUT'(run_sum * 29));
            run_sum = 0;
         end
      end
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !res_valid) begin done = 1'b1; break; end
      end
      @(posedge clk); #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: busy=%0b res_valid=%0b pending=%0d, expected idle", name, busy, res_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0; cfg_len = 8'd4;
      idle(3);
      @(negedge clk);
      checks++;
      if ({in_ready, res_valid, busy, macc_ce, macc_sload} !== 5'b0 || res_data !== '0 || macc_a !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%0b rv=%0b busy=%0b ce=%0b sl=%0b rd=%0d a=%0d, expected all 0",
                  in_ready, res_valid, busy, macc_ce, macc_sload, res_data, macc_a);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%0b busy=%0b expected 1 0", in_ready, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame();
      res_ready = 1'b1; cfg_len = 8'd4; clear_stats();
      send(1, 0); send(2, 0); send(3, 0); send(4, 1);
      drain("single");
      checks++;
      if (res_cnt != 1) begin
         errors++;
         $display("FAIL single_count: got %0d results expected 1", res_cnt);
      end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1; cfg_len = 8'd2; clear_stats();
      send(5, 0); send(-3, 1); send(7, 0); send(7, 1);
      drain("b2b");
      checks++;
      if (sload_mask !== 32'b1010) begin
         errors++;
         $display("FAIL b2b_sload: got mask %b expected 1010", sload_mask);
      end
      checks++;
      if (res_cnt != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d results expected 2", res_cnt);
      end
   endtask

   task automatic test_len1();
      res_ready = 1'b1; cfg_len = 8'd1; clear_stats();
      send(100, 1);
      drain("len1");
      checks++;
      if (flush_cnt != 2) begin
         errors++;
         $display("FAIL len1_flush: got %0d flush cycles expected 2", flush_cnt);
      end
      cfg_len = 8'd0; clear_stats();
      send(7, 1);
      drain("len0");
      checks++;
      if (res_cnt != 1) begin
         errors++;
         $display("FAIL len0_count: got %0d results expected 1", res_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic signed [SIZEOUT-1:0] held;
      held = -40'sd2850816;
      res_ready = 1'b0; cfg_len = 8'd3; clear_stats();
      send(-32768, 0); send(-32768, 0); send(-32768, 1);
      send(1, 0); send(2, 0); send(3, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== held || in_ready !== 1'b0 || macc_ce !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: rv=%0b rd=%0d rdy=%0b ce=%0b expected 1 %0d 0 0",
                     res_valid, res_data, in_ready, macc_ce, held);
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      drain("bp");
      checks++;
      if (res_cnt != 2) begin
         errors++;
         $display("FAIL bp_count: got %0d results expected 2", res_cnt);
      end
   endtask

   task automatic test_gaps();
      res_ready = 1'b1; cfg_len = 8'd4; clear_stats();
      send(10, 0);
      cfg_len = 8'd1;
      idle(2); send(-20, 0);
      idle(3); send(30, 0);
      idle(1); send(-40, 1);
      drain("gaps");
      checks++;
      if (res_cnt != 1) begin
         errors++;
         $display("FAIL gaps_count: got %0d results expected 1", res_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      res_ready = 1'b1; cfg_len = 8'd4; clear_stats();
      send(11, 0); send(22, 0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, res_valid, busy, macc_ce, macc_sload} !== 5'b0 || res_data !== '0 || macc_a !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: rdy=%0b rv=%0b busy=%0b ce=%0b sl=%0b rd=%0d a=%0d, expected all 0",
                  in_ready, res_valid, busy, macc_ce, macc_sload, res_data, macc_a);
      end
      idle(2);
      run_sum = 0;
      rst = 1'b0;
      idle(1);
      cfg_len = 8'd2;
      send(1, 0); send(1, 1);
      drain("midrst");
      checks++;
      if (res_cnt != 1) begin
         errors++;
         $display("FAIL midrst_count: got %0d results expected 1", res_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_len1();
      test_backpressure();
      test_gaps();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
